rtc_bus_sequencer: RTL and testbench

- Owns the multiplexed address/data bus to the external RTC chip: AD, CS, RD and WR, plus the bidirectional 8-bit data bus.
- Arbitrates between two requesters:
  - the PicoBlaze host port, for single register reads/writes;
  - an internal refresh engine that periodically reads a contiguous block of RTC registers for the VGA display registers.
- Replaces ad-hoc muxing of separate write/read cycle generators with one timed transaction state machine.

---
 rtl/rtc_bus_sequencer.sv | 202 ++++++++++++++++++++
 tb/tb_rtc_bus_sequencer.sv | 259 +++++++++++++++++++++++++
 2 files changed

// File: rtl/rtc_bus_sequencer.sv
// Single timed transaction engine for the multiplexed RTC bus, shared between
// host register accesses and a periodic block-read refresh engine.
module rtc_bus_sequencer #(
    parameter int          T_ADDR       = 2,
    parameter int          T_HOLD       = 1,
    parameter int          T_DATA       = 3,
    parameter int          T_REC        = 2,
    parameter int          REFRESH_DIV  = 1000,
    parameter logic [7:0]  REFRESH_BASE = 8'h00,
    parameter int          N_REFRESH    = 9
) (
    input  logic       Clk,
    input  logic       Reset,
    input  logic       host_req,
    input  logic       host_rnw,
    input  logic [7:0] host_addr,
    input  logic [7:0] host_wdata,
    output logic       host_busy,
    output logic       host_done,
    output logic [7:0] host_rdata,
    input  logic       refresh_en,
    output logic       upd_valid,
    output logic [3:0] upd_index,
    output logic [7:0] upd_data,
    input  logic [7:0] bus_in,
    output logic [7:0] bus_out,
    output logic       bus_oe,
    output logic       AD,
    output logic       CS,
    output logic       RD,
    output logic       WR
);

    localparam int CW = (REFRESH_DIV > 2) ? $clog2(REFRESH_DIV) : 1;

    typedef enum logic [2:0] {IDLE, ADDR, HOLD, DATA, REC} state_t;

    state_t          state_q, state_d;
    logic [3:0]      cnt_q, cnt_d;
    logic            gnt_h, gnt_r;

    logic            hp_q, h_rnw_q, busy_q;
    logic [7:0]      h_addr_q, h_wdata_q;
    logic            rp_q, lg_q;
    logic [CW-1:0]   rcnt_q;
    logic [3:0]      idx_q;
    logic            tick;

    logic            own_q, own_d, rnw_q, rnw_d;
    logic [7:0]      addr_q, addr_d, wdata_q, wdata_d;
    logic [7:0]      smp_q;
    logic            done_q, uv_q;
    logic [7:0]      hrd_q, ud_q;
    logic [3:0]      ui_q;

    logic            ad_q, cs_q, rd_q, wr_q, oe_q;
    logic            ad_d, cs_d, rd_d, wr_d, oe_d;
    logic [7:0]      bo_q, bo_d;

    logic            last;
    assign last = (cnt_q == 4'd0);
    assign tick = refresh_en && (rcnt_q == CW'(REFRESH_DIV - 1));

    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            state_q <= IDLE;
            cnt_q   <= 4'd0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    // Arbitration only happens in IDLE; lg_q=1 means refresh was granted last.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        gnt_h   = 1'b0;
        gnt_r   = 1'b0;
        case (state_q)
            IDLE: begin
                if (hp_q && (!rp_q || lg_q)) gnt_h = 1'b1;
                else if (rp_q)               gnt_r = 1'b1;
                if (gnt_h || gnt_r) begin
                    state_d = ADDR;
                    cnt_d   = 4'(T_ADDR - 1);
                end
            end
            ADDR: if (last) begin state_d = HOLD; cnt_d = 4'(T_HOLD - 1); end
                  else cnt_d = cnt_q - 4'd1;
            HOLD: if (last) begin state_d = DATA; cnt_d = 4'(T_DATA - 1); end
                  else cnt_d = cnt_q - 4'd1;
            DATA: if (last) begin state_d = REC;  cnt_d = 4'(T_REC - 1); end
                  else cnt_d = cnt_q - 4'd1;
            REC:  if (last) begin state_d = IDLE; cnt_d = 4'd0; end
                  else cnt_d = cnt_q - 4'd1;
            default: begin state_d = IDLE; cnt_d = 4'd0; end
        endcase
    end

    always_comb begin
        own_d   = own_q;
        rnw_d   = rnw_q;
        addr_d  = addr_q;
        wdata_d = wdata_q;
        if (gnt_h) begin
            own_d   = 1'b0;
            rnw_d   = h_rnw_q;
            addr_d  = h_addr_q;
            wdata_d = h_wdata_q;
        end else if (gnt_r) begin
            own_d   = 1'b1;
            rnw_d   = 1'b1;
            addr_d  = REFRESH_BASE + {4'h0, idx_q};
        end
    end

    // Pad outputs are decoded from the next state and registered, so strobes
    // change only on clock edges and line up with the state register.
    always_comb begin
        ad_d = 1'b1; cs_d = 1'b1; rd_d = 1'b1; wr_d = 1'b1;
        oe_d = 1'b0; bo_d = 8'h00;
        case (state_d)
            ADDR: begin cs_d = 1'b0; ad_d = 1'b0; oe_d = 1'b1; bo_d = addr_d; end
            HOLD: begin oe_d = 1'b1; bo_d = addr_d; end
            DATA: begin
                cs_d = 1'b0;
                if (rnw_d) rd_d = 1'b0;
                else begin wr_d = 1'b0; oe_d = 1'b1; bo_d = wdata_d; end
            end
            default: ;
        endcase
    end

    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            hp_q <= 1'b0; h_rnw_q <= 1'b0; h_addr_q <= 8'h00; h_wdata_q <= 8'h00;
            busy_q <= 1'b0;
            rp_q <= 1'b0; lg_q <= 1'b1; rcnt_q <= '0; idx_q <= 4'd0;
            own_q <= 1'b0; rnw_q <= 1'b0; addr_q <= 8'h00; wdata_q <= 8'h00;
            smp_q <= 8'h00;
            done_q <= 1'b0; hrd_q <= 8'h00;
            uv_q <= 1'b0; ui_q <= 4'd0; ud_q <= 8'h00;
            ad_q <= 1'b1; cs_q <= 1'b1; rd_q <= 1'b1; wr_q <= 1'b1;
            oe_q <= 1'b0; bo_q <= 8'h00;
        end else begin
            if (host_req && !busy_q) begin
                hp_q      <= 1'b1;
                h_rnw_q   <= host_rnw;
                h_addr_q  <= host_addr;
                h_wdata_q <= host_wdata;
            end else if (gnt_h) begin
                hp_q <= 1'b0;
            end

            if (done_q)                    busy_q <= 1'b0;
            else if (host_req && !busy_q)  busy_q <= 1'b1;

            if (refresh_en) rcnt_q <= tick ? '0 : rcnt_q + 1'b1;
            if (gnt_r)      rp_q <= 1'b0;
            else if (tick)  rp_q <= 1'b1;

            if (gnt_h) lg_q <= 1'b0;
            if (gnt_r) lg_q <= 1'b1;

            own_q <= own_d; rnw_q <= rnw_d; addr_q <= addr_d; wdata_q <= wdata_d;

            if (state_q == DATA && last) smp_q <= bus_in;

            done_q <= 1'b0;
            uv_q   <= 1'b0;
            if (state_q == REC && last) begin
                if (own_q) begin
                    uv_q  <= 1'b1;
                    ui_q  <= idx_q;
                    ud_q  <= smp_q;
                    idx_q <= (idx_q == 4'(N_REFRESH - 1)) ? 4'd0 : idx_q + 4'd1;
                end else begin
                    done_q <= 1'b1;
                    if (rnw_q) hrd_q <= smp_q;
                end
            end

            ad_q <= ad_d; cs_q <= cs_d; rd_q <= rd_d; wr_q <= wr_d;
            oe_q <= oe_d; bo_q <= bo_d;
        end
    end

    assign host_busy  = busy_q;
    assign host_done  = done_q;
    assign host_rdata = hrd_q;
    assign upd_valid  = uv_q;
    assign upd_index  = ui_q;
    assign upd_data   = ud_q;
    assign AD         = ad_q;
    assign CS         = cs_q;
    assign RD         = rd_q;
    assign WR         = wr_q;
    assign bus_oe     = oe_q;
    assign bus_out    = bo_q;

endmodule

// File: tb/tb_rtc_bus_sequencer.sv
// Directed bench for rtc_bus_sequencer: host write/read timing, refresh block
// reads, arbitration, busy filtering and asynchronous reset mid-transaction.
module tb_rtc_bus_sequencer;

    logic       Clk = 1'b0;
    logic       Reset;
    logic       host_req, host_rnw;
    logic [7:0] host_addr, host_wdata;
    logic       host_busy, host_done;
    logic [7:0] host_rdata;
    logic       refresh_en;
    logic       upd_valid;
    logic [3:0] upd_index;
    logic [7:0] upd_data;
    logic [7:0] bus_in, bus_out;
    logic       bus_oe, AD, CS, RD, WR;

    int total = 0;
    int bad   = 0;

    logic [7:0]  tb_bus = 8'hEE;
    logic [7:0]  tb_addr = 8'h00;
    logic        tb_mode = 1'b0;
    logic        prev_ad = 1'b1;
    logic [7:0]  adrs[$];
    logic [11:0] upds[$];
    int          dones = 0;

    // In refresh mode the fake RTC returns A0 ^ address for every read.
    assign bus_in = tb_mode ? (8'hA0 ^ tb_addr) : tb_bus;

    rtc_bus_sequencer #(.REFRESH_DIV(20), .N_REFRESH(3)) dut (
        .Clk(Clk), .Reset(Reset),
        .host_req(host_req), .host_rnw(host_rnw), .host_addr(host_addr),
        .host_wdata(host_wdata), .host_busy(host_busy), .host_done(host_done),
        .host_rdata(host_rdata), .refresh_en(refresh_en),
        .upd_valid(upd_valid), .upd_index(upd_index), .upd_data(upd_data),
        .bus_in(bus_in), .bus_out(bus_out), .bus_oe(bus_oe),
        .AD(AD), .CS(CS), .RD(RD), .WR(WR)
    );

    always #5 Clk = ~Clk;

    always @(negedge Clk) begin
        if (AD === 1'b0 && prev_ad === 1'b1) adrs.push_back(bus_out);
        if (AD === 1'b0) tb_addr = bus_out;
        prev_ad = AD;
        if (host_done === 1'b1) dones++;
        if (upd_valid === 1'b1) upds.push_back({upd_index, upd_data});
    end

    task automatic tick();
        @(posedge Clk);
        #1;
    endtask

    task automatic test_reset();
        Reset = 1'b1;
        tick();
        total++;
        if ({AD, CS, RD, WR, bus_oe} !== 5'b11110 || bus_out !== 8'h00) begin
            bad++;
            $display("FAIL reset_pads: got AD/CS/RD/WR/oe=%b out=%h want 11110 out=00",
                     {AD, CS, RD, WR, bus_oe}, bus_out);
        end
        total++;
        if ({host_busy, host_done, upd_valid} !== 3'b000 || host_rdata !== 8'h00 ||
            upd_data !== 8'h00 || upd_index !== 4'h0) begin
            bad++;
            $display("FAIL reset_status: got busy/done/uv=%b rdata=%h udata=%h uidx=%h want all zero",
                     {host_busy, host_done, upd_valid}, host_rdata, upd_data, upd_index);
        end
        Reset = 1'b0;
        tick();
    endtask

    // Host transaction with default timing: k counts cycles after the request cycle.
    task automatic test_host_txn(input logic rnw, input logic [7:0] addr,
                                 input logic [7:0] wdata, input logic [7:0] rdval,
                                 input logic [7:0] rdexp);
        logic [6:0] exp_v, got_v;
        logic       in_data, oe_e;
        tick();
        host_req = 1'b1; host_rnw = rnw; host_addr = addr; host_wdata = wdata;
        tick();
        host_req = 1'b0;
        for (int k = 1; k <= 11; k++) begin
            in_data = (k >= 5 && k <= 7);
            tb_bus  = in_data ? rdval : 8'hEE;
            oe_e    = (k >= 2 && k <= 4) || (!rnw && in_data);
            exp_v = {!(k == 2 || k == 3), !((k == 2 || k == 3) || in_data),
                     !(rnw && in_data), !(!rnw && in_data), oe_e, k == 10, k <= 10};
            got_v = {AD, CS, RD, WR, bus_oe, host_done, host_busy};
            total++;
            if (got_v !== exp_v) begin
                bad++;
                $display("FAIL host_strobes k=%0d: got AD/CS/RD/WR/oe/done/busy=%b want %b",
                         k, got_v, exp_v);
            end
            if (oe_e) begin
                total++;
                if (bus_out !== ((k <= 4) ? addr : wdata)) begin
                    bad++;
                    $display("FAIL host_bus_out k=%0d: got %h want %h",
                             k, bus_out, (k <= 4) ? addr : wdata);
                end
            end
            if (k == 10) begin
                total++;
                if (host_rdata !== rdexp) begin
                    bad++;
                    $display("FAIL host_rdata: got %h want %h", host_rdata, rdexp);
                end
            end
            tick();
        end
        tb_bus = 8'hEE;
    endtask

    task automatic test_refresh();
        logic [7:0] a;
        adrs.delete(); upds.delete();
        tb_mode = 1'b1;
        refresh_en = 1'b1;
        for (int c = 0; c < 300 && upds.size() < 4; c++) tick();
        refresh_en = 1'b0;
        repeat (12) tick();
        total++;
        if (upds.size() < 4 || adrs.size() < 4) begin
            bad++;
            $display("FAIL refresh_count: got upd=%0d addr=%0d want >=4 each",
                     upds.size(), adrs.size());
        end else begin
            for (int i = 0; i < 4; i++) begin
                a = 8'(i % 3);
                total++;
                if (adrs[i] !== a) begin
                    bad++;
                    $display("FAIL refresh_addr[%0d]: got %h want %h", i, adrs[i], a);
                end
                total++;
                if (upds[i] !== {a[3:0], 8'hA0 ^ a}) begin
                    bad++;
                    $display("FAIL refresh_upd[%0d]: got idx/data=%h want %h",
                             i, upds[i], {a[3:0], 8'hA0 ^ a});
                end
            end
        end
        tb_mode = 1'b0;
    endtask

    task automatic test_arbitration();
        logic [7:0] exp_a [6];
        Reset = 1'b1;
        tick();
        Reset = 1'b0;
        adrs.delete(); upds.delete();
        tb_mode = 1'b1;
        refresh_en = 1'b1;
        // The refresh tick lands on the 20th edge; the host request shares it.
        repeat (19) tick();
        host_req = 1'b1; host_rnw = 1'b1; host_addr = 8'h55; host_wdata = 8'h00;
        tick();
        host_req = 1'b0;
        for (int h = 1; h <= 2; h++) begin
            for (int c = 0; c < 100 && host_busy !== 1'b0; c++) tick();
            host_req = 1'b1; host_addr = 8'h55 + 8'(h);
            tick();
            host_req = 1'b0;
        end
        for (int c = 0; c < 200 && adrs.size() < 6; c++) tick();
        refresh_en = 1'b0;
        exp_a = '{8'h55, 8'h00, 8'h56, 8'h01, 8'h57, 8'h02};
        total++;
        if (adrs.size() < 6) begin
            bad++;
            $display("FAIL arb_count: got %0d transactions want 6", adrs.size());
        end else begin
            for (int i = 0; i < 6; i++) begin
                total++;
                if (adrs[i] !== exp_a[i]) begin
                    bad++;
                    $display("FAIL arb_order[%0d]: got %h want %h", i, adrs[i], exp_a[i]);
                end
            end
        end
        repeat (20) tick();
        tb_mode = 1'b0;
    endtask

    task automatic test_busy_ignore();
        adrs.delete(); dones = 0;
        host_req = 1'b1; host_rnw = 1'b0; host_addr = 8'h33; host_wdata = 8'h77;
        tick();
        host_req = 1'b0;
        repeat (2) tick();
        host_req = 1'b1; host_addr = 8'h44; host_wdata = 8'h88;
        tick();
        host_req = 1'b0;
        repeat (25) tick();
        total++;
        if (adrs.size() !== 1 || dones !== 1) begin
            bad++;
            $display("FAIL busy_ignore_count: got txns=%0d dones=%0d want 1 and 1",
                     adrs.size(), dones);
        end else begin
            total++;
            if (adrs[0] !== 8'h33) begin
                bad++;
                $display("FAIL busy_ignore_addr: got %h want 33", adrs[0]);
            end
        end
    endtask

    task automatic test_reset_mid();
        dones = 0;
        host_req = 1'b1; host_rnw = 1'b0; host_addr = 8'h12; host_wdata = 8'h34;
        tick();
        host_req = 1'b0;
        repeat (5) tick();
        total++;
        if (WR !== 1'b0) begin
            bad++;
            $display("FAIL mid_data_wr: got WR=%b want 0", WR);
        end
        Reset = 1'b1;
        #1;
        total++;
        if ({AD, CS, RD, WR, bus_oe, host_busy} !== 6'b111100) begin
            bad++;
            $display("FAIL mid_reset_pads: got AD/CS/RD/WR/oe/busy=%b want 111100",
                     {AD, CS, RD, WR, bus_oe, host_busy});
        end
        tick();
        Reset = 1'b0;
        repeat (15) tick();
        total++;
        if (dones !== 0) begin
            bad++;
            $display("FAIL mid_reset_done: got %0d done pulses want 0", dones);
        end
        test_host_txn(1'b0, 8'h12, 8'h34, 8'hEE, 8'h00);
    endtask

    initial begin
        Reset = 1'b1; host_req = 1'b0; host_rnw = 1'b0;
        host_addr = 8'h00; host_wdata = 8'h00; refresh_en = 1'b0;
        test_reset();
        test_host_txn(1'b0, 8'h0A, 8'h26, 8'hEE, 8'h00);
        test_host_txn(1'b1, 8'h04, 8'h00, 8'h15, 8'h15);
        test_refresh();
        test_arbitration();
        test_busy_ignore();
        test_reset_mid();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
